// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
// Buffers signed 16-bit audio samples in a small FIFO. On each audio-rate tick
// it pops one sample, converts it to 12-bit offset-binary with rounding and
// saturation, and hands it to the SPI DAC controller through a send/busy
// handshake. The controller's busy flag lives in the SCLK domain and is
// resynchronised here. Also reports FIFO level, underruns and late ticks.
module dac_sample_scheduler #(
    parameter int CLK_DIVIDE = 2268,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic               clock_50Mhz,
    input  logic               reset_n,
    input  logic signed [15:0] in_sample,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [11:0]        dac_sample,
    output logic               dac_send_n,
    input  logic               dac_busy,
    output logic [ADDR_W:0]    fifo_level,
    output logic [15:0]        underrun_count,
    output logic               late_tick
);

    localparam int CNT_W = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLK_DIVIDE - 1);
    localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [11:0]       DAC_MID    = 12'h800;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQUEST   = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    // Round to 12 bits (add half an LSB of the result), clamp the single
    // positive overflow case, and flip the sign bit for offset-binary.
    function automatic logic [11:0] to_offset12(input logic signed [15:0] s);
        logic signed [16:0] r;
        r = $signed({s[15], s}) + 17'sd8;
        if (r > 17'sd32767) begin
            r = 17'sd32767;
        end
        return {~r[15], r[14:4]};
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [1:0]         state_q, state_d;
    logic               send_n_q, send_n_d;
    logic [11:0]        dac_sample_q, dac_sample_d;
    logic [15:0]        underrun_q, underrun_d;
    logic               late_q, late_d;
    logic [ADDR_W:0]    level_q, level_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic               busy_meta_q, busy_s_q;
    logic signed [15:0] mem_q [FIFO_DEPTH];

    logic tick;
    logic fifo_empty;
    logic pop;
    logic push;
    logic in_ready_c;

    // Tick generation, transfer FSM, and FIFO pointer/level bookkeeping.
    always_comb begin
        tick         = (tick_cnt_q == CNT_LAST);
        tick_cnt_d   = tick ? '0 : tick_cnt_q + CNT_W'(1);
        fifo_empty   = (level_q == '0);

        pop          = 1'b0;
        state_d      = state_q;
        send_n_d     = send_n_q;
        dac_sample_d = dac_sample_q;
        underrun_d   = underrun_q;
        late_d       = late_q;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        dac_sample_d = to_offset12(mem_q[rd_ptr_q]);
                        send_n_d     = 1'b0;
                        state_d      = REQUEST;
                    end else begin
                        underrun_d   = sat_inc16(underrun_q);
                    end
                end
            end
            REQUEST: begin
                // A tick here is dropped; the downstream is too slow.
                if (tick) begin
                    late_d = 1'b1;
                end
                if (busy_s_q) begin
                    send_n_d = 1'b1;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tick) begin
                    late_d = 1'b1;
                end
                if (!busy_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                send_n_d = 1'b1;
            end
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO can still
        // accept a sample on the tick that drains one.
        in_ready_c = (level_q != LEVEL_FULL) || pop;
        push       = in_valid && in_ready_c;

        wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state, registered outputs and the busy synchroniser.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q   <= '0;
            state_q      <= IDLE;
            send_n_q     <= 1'b1;
            dac_sample_q <= DAC_MID;
            underrun_q   <= '0;
            late_q       <= 1'b0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            busy_meta_q  <= 1'b0;
            busy_s_q     <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            state_q      <= state_d;
            send_n_q     <= send_n_d;
            dac_sample_q <= dac_sample_d;
            underrun_q   <= underrun_d;
            late_q       <= late_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            busy_meta_q  <= dac_busy;
            busy_s_q     <= busy_meta_q;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clock_50Mhz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_sample;
        end
    end

    assign in_ready       = in_ready_c;
    assign dac_sample     = dac_sample_q;
    assign dac_send_n     = send_n_q;
    assign fifo_level     = level_q;
    assign underrun_count = underrun_q;
    assign late_tick      = late_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler with a shortened tick period and a
// scaled DAC controller model answering the send/busy handshake.
module tb_dac_sample_scheduler;

    localparam int TB_DIV   = 100;
    localparam int BUSY_DLY = 8;
    localparam int BUSY_LEN = 40;

    logic               clk = 1'b0;
    logic               reset_n;
    logic signed [15:0] in_sample;
    logic               in_valid;
    logic               in_ready;
    logic [11:0]        dac_sample;
    logic               dac_send_n;
    logic               dac_busy;
    logic [3:0]         fifo_level;
    logic [15:0]        underrun_count;
    logic               late_tick;

    logic dac_auto;
    logic man_busy;
    logic model_busy;
    int   mcnt;
    int   tcnt;
    int   cyc = 0;
    int   pulses = 0;
    int   t_busy = 0;
    int   last_delay = -1;
    logic prev_send = 1'b1;
    logic prev_busy = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign dac_busy = dac_auto ? model_busy : man_busy;

    dac_sample_scheduler #(
        .CLK_DIVIDE(TB_DIV),
        .FIFO_DEPTH(8),
        .ADDR_W(3)
    ) dut (
        .clock_50Mhz   (clk),
        .reset_n       (reset_n),
        .in_sample     (in_sample),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dac_sample    (dac_sample),
        .dac_send_n    (dac_send_n),
        .dac_busy      (dac_busy),
        .fifo_level    (fifo_level),
        .underrun_count(underrun_count),
        .late_tick     (late_tick)
    );

    // Reference tick counter: a tick is acted on at the edge where tcnt == TB_DIV-1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tcnt <= 0;
        else          tcnt <= (tcnt == TB_DIV - 1) ? 0 : tcnt + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // DAC controller model: busy rises BUSY_DLY cycles after send_n low, holds BUSY_LEN.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt       <= 0;
            model_busy <= 1'b0;
        end else if (mcnt != 0) begin
            if (mcnt == BUSY_DLY) model_busy <= 1'b1;
            if (mcnt == BUSY_DLY + BUSY_LEN) begin
                model_busy <= 1'b0;
                mcnt       <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else if (dac_auto && !dac_send_n && !model_busy) begin
            mcnt <= 1;
        end
    end

    // Handshake monitor: send pulse count and busy-rise to send_n-rise delay.
    always @(negedge clk) begin
        if (prev_send && !dac_send_n) pulses = pulses + 1;
        if (!prev_busy && dac_busy) t_busy = cyc;
        if (!prev_send && dac_send_n && reset_n) last_delay = cyc - t_busy;
        prev_send = dac_send_n;
        prev_busy = dac_busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] x, output logic acc);
        @(negedge clk);
        in_sample = x;
        in_valid  = 1'b1;
        acc       = in_ready;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_tick();
        @(negedge clk);
        while (tcnt != TB_DIV - 1) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        accs [9];
        logic [15:0] conv_in  [6];
        logic [11:0] conv_exp [6];
        logic [11:0] drain_exp[8];

        conv_in  = '{16'h0000, 16'h7FFF, 16'h8000, 16'h7FF8, 16'h0017, 16'hFFFF};
        conv_exp = '{12'h800, 12'hFFF, 12'h000, 12'hFFF, 12'h801, 12'h800};
        drain_exp = '{12'h900, 12'hA00, 12'hB00, 12'hC00, 12'hD00, 12'hE00, 12'hF00, 12'hFFF};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        dac_auto  = 1'b1;
        man_busy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready",   in_ready, 1);
        check_eq("rst_dac_sample", dac_sample, 12'h800);
        check_eq("rst_send_n",     dac_send_n, 1);
        check_eq("rst_level",      fifo_level, 0);
        check_eq("rst_underrun",   underrun_count, 0);
        check_eq("rst_late",       late_tick, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Conversion through six ticks with the DAC model answering
        for (int i = 0; i < 6; i++) begin
            push(conv_in[i], acc);
            if (i == 0) check_eq("push_level_1cyc", fifo_level, 1);
        end
        check_eq("conv_level_6", fifo_level, 6);
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            check_eq($sformatf("conv_%0d", i), dac_sample, conv_exp[i]);
            check_eq($sformatf("conv_send_%0d", i), dac_send_n, 0);
        end

        // Underrun on an empty FIFO
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            check_eq($sformatf("under_send_%0d", i), dac_send_n, 1);
        end
        check_eq("under_count_3",    underrun_count, 3);
        check_eq("under_sample",     dac_sample, 12'h800);
        check_eq("hs_pulses_6",      pulses, 6);
        check_eq("hs_busy_to_send",  last_delay, 3);
        check_eq("hs_no_late",       late_tick, 0);

        // Stalled downstream: busy held high across two ticks
        push(16'h0017, acc);
        push(16'h1000, acc);
        dac_auto = 1'b0;
        man_busy = 1'b0;
        wait_tick();
        check_eq("stall_pop_sample", dac_sample, 12'h801);
        check_eq("stall_send_low",   dac_send_n, 0);
        check_eq("stall_level_1",    fifo_level, 1);
        repeat (5) @(posedge clk);
        #1;
        man_busy = 1'b1;
        wait_tick();
        wait_tick();
        check_eq("stall_late",       late_tick, 1);
        check_eq("stall_level_kept", fifo_level, 1);
        check_eq("stall_underrun",   underrun_count, 3);
        check_eq("stall_sample_hold", dac_sample, 12'h801);
        check_eq("stall_send_hi",    dac_send_n, 1);
        check_eq("stall_busy_delay", last_delay, 3);
        man_busy = 1'b0;
        repeat (5) @(posedge clk);
        dac_auto = 1'b1;
        wait_tick();
        check_eq("stall_resume",     dac_sample, 12'h900);
        check_eq("stall_level_0",    fifo_level, 0);

        // FIFO fill: nine back-to-back pushes, then push+pop at full
        for (int i = 0; i < 9; i++) begin
            push(16'(i * 16'h1000), acc);
            accs[i] = acc;
            if (i == 7) begin
                check_eq("fill_ready_low", in_ready, 0);
                check_eq("fill_level_8",   fifo_level, 8);
            end
        end
        check_eq("fill_8th_acc",    accs[7], 1);
        check_eq("fill_9th_rej",    accs[8], 0);
        check_eq("fill_level_still", fifo_level, 8);
        @(negedge clk);
        while (tcnt != TB_DIV - 1) @(negedge clk);
        in_sample = 16'h7FFF;
        in_valid  = 1'b1;
        check_eq("full_ready_on_pop", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("full_pushpop_level", fifo_level, 8);
        check_eq("full_pop_first",     dac_sample, 12'h800);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            check_eq($sformatf("drain_%0d", i), dac_sample, drain_exp[i]);
        end
        check_eq("drain_level_0", fifo_level, 0);

        // Underrun counter saturation
        force dut.underrun_q = 16'hFFFE;
        repeat (2) @(posedge clk);
        #1;
        release dut.underrun_q;
        wait_tick();
        check_eq("sat_reach", underrun_count, 16'hFFFF);
        check_eq("sat_sample_kept", dac_sample, 12'hFFF);
        wait_tick();
        check_eq("sat_hold", underrun_count, 16'hFFFF);
        check_eq("sat_send_n", dac_send_n, 1);

        // Reset while in REQUEST with four samples queued
        dac_auto = 1'b0;
        man_busy = 1'b0;
        for (int i = 0; i < 5; i++) push(16'h2000, acc);
        wait_tick();
        check_eq("mid_send_low", dac_send_n, 0);
        check_eq("mid_level_4",  fifo_level, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_send_n",   dac_send_n, 1);
        check_eq("mid_rst_level",    fifo_level, 0);
        check_eq("mid_rst_sample",   dac_sample, 12'h800);
        check_eq("mid_rst_state",    dut.state_q, 0);
        check_eq("mid_rst_underrun", underrun_count, 0);
        check_eq("mid_rst_late",     late_tick, 0);
        check_eq("mid_rst_ready",    in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_sample_scheduler.md
# dac_sample_scheduler

Upstream feeder for the SPI DAC output controller. It accepts signed 16-bit audio samples from the synthesis path into a small FIFO and converts each one to 12-bit offset-binary with rounding and saturation. It releases exactly one sample to the DAC controller per audio-rate tick (~22.05 kHz) through a send/busy handshake that crosses into the controller's ~714 kHz SCLK domain. It also reports FIFO level, underruns and late ticks.

## Interface
- CLK_DIVIDE, 2268: clock_50Mhz cycles per sample tick (50 MHz / 2268 = 22045.9 Hz).
- FIFO_DEPTH, 8: FIFO entries; power of two, minimum 2.
- ADDR_W, 3: log2(FIFO_DEPTH).
- clock_50Mhz  in  1  system clock; all logic on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_sample  in  16  signed two's-complement audio sample.
- in_valid  in  1  in_sample is presented this cycle.
- in_ready  out  1  FIFO not full; a push occurs when in_valid && in_ready.
- dac_sample  out  12  offset-binary sample to the DAC controller's sample input.
- dac_send_n  out  1  active-low send request to the DAC controller.
- dac_busy  in  1  DAC controller busy flag (SCLK domain; synchronised here).
- fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- underrun_count  out  16  ticks that found the FIFO empty; saturates at 0xFFFF.
- late_tick  out  1  sticky flag: a tick arrived while a transfer was still in progress.

## Operation
- Reset values: in_ready=1, dac_sample=0x800, dac_send_n=1, fifo_level=0, underrun_count=0, late_tick=0, tick counter=0, state=IDLE, synchroniser flops=0.
- Conversion (applied at pop): r = in_sample + 8, computed in 17 bits. If r > 32767, r = 32767. dac_sample = {~r[15], r[14:4]}.
- FIFO: circular buffer with ADDR_W-bit pointers that wrap. A push when full is impossible because in_ready=0. Push and pop in the same cycle are allowed at any level, including full, and leave the level unchanged.
- Tick: a counter runs 0..CLK_DIVIDE-1 and wraps. tick=1 for one cycle when the counter equals CLK_DIVIDE-1.
- busy_s = dac_busy passed through 2 flops in the clock_50Mhz domain.
- FSM states and transitions:
  - IDLE: on tick with FIFO non-empty, pop, latch the converted value into dac_sample, drive dac_send_n=0, go to REQUEST. On tick with FIFO empty, increment underrun_count (saturating), leave dac_sample unchanged, send nothing, stay in IDLE.
  - REQUEST: hold dac_send_n=0 until busy_s=1. Then dac_send_n=1 and go to WAIT_DONE.
  - WAIT_DONE: when busy_s=0, go to IDLE.
- A tick in REQUEST or WAIT_DONE sets late_tick=1 (cleared only by reset). That tick is dropped: no pop and no underrun increment.
- dac_sample is stable from the cycle dac_send_n falls until the block returns to IDLE.
- Reset mid-transfer: all state returns to reset values immediately and FIFO contents are discarded. The DAC controller shares reset_n.

## Timing
- Push to fifo_level update: 1 cycle.
- Tick to dac_send_n low and dac_sample valid: 1 cycle (registered outputs).
- dac_busy rise to dac_send_n high: 3 cycles (2 synchroniser stages + 1 registered update).
- dac_send_n stays low for at least one full SCLK period (~70 clock_50Mhz cycles) because release waits for the controller's busy response.
- A nominal DAC frame is about 21 SCLK periods (~29.4 µs), well inside the 45.4 µs tick period. late_tick therefore flags a stalled or faulty downstream.
- Samples leave the FIFO at most one per tick. Steady-state throughput equals the tick rate.

## Test plan
- Conversion: push 0x0000, 0x7FFF, 0x8000, 0x7FF8, 0x0017, 0xFFFF -> successive ticks give dac_sample 0x800, 0xFFF, 0x000, 0xFFF, 0x801, 0x800.
- Handshake with a DAC model (busy rises 2 SCLK after send_n low, stays high 20 SCLK) -> exactly one send_n low pulse per tick, send_n high 3 cycles after busy rises, no late_tick.
- FIFO fill: push 9 samples back-to-back with no ticks -> in_ready=0 after the 8th push, fifo_level=8, 9th sample not accepted. Simultaneous push and pop at full -> level stays 8 and order is preserved.
- Underrun: empty FIFO for 3 ticks -> underrun_count=3, dac_send_n stays 1, dac_sample unchanged. Force the count to 0xFFFF, then one more empty tick -> stays 0xFFFF.
- Stalled downstream: hold dac_busy=1 across 2 ticks -> late_tick=1, FIFO level unchanged by those ticks, underrun_count unchanged.
- Reset in REQUEST with 4 samples queued -> next cycle dac_send_n=1, fifo_level=0, dac_sample=0x800, state=IDLE.
